// File: rtl/ram_sp_port_ctrl.sv
// Single-port table RAM front end: zero-latency lookups, posted updates through a
// forwarding FIFO, and a hardware clear sweep that writes INITVALUE to every entry.
module ram_sp_port_ctrl #(
  parameter int                   DATAWIDTH = 64,
  parameter int                   INDEXSIZE = 256,
  parameter int                   LOGINDEX  = 8,
  parameter logic [DATAWIDTH-1:0] INITVALUE = '0,
  parameter int                   FIFODEPTH = 4,
  parameter int                   LOGFIFO   = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 lkp_valid_in,
  input  logic [LOGINDEX-1:0]  lkp_index_in,
  output logic                 lkp_ready_out,
  output logic [DATAWIDTH-1:0] lkp_data_out,
  input  logic                 upd_valid_in,
  input  logic [LOGINDEX-1:0]  upd_index_in,
  input  logic [DATAWIDTH-1:0] upd_data_in,
  output logic                 upd_ready_out,
  input  logic                 clr_in,
  output logic                 busy_out,
  output logic                 ram_we_out,
  output logic [LOGINDEX-1:0]  ram_index_out,
  output logic [DATAWIDTH-1:0] ram_data_out,
  input  logic [DATAWIDTH-1:0] ram_data_in
);

  localparam int CNTW = LOGFIFO + 1;
  localparam int CLRW = LOGINDEX + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFODEPTH);
  localparam logic [CLRW-1:0] LAST_IDX = CLRW'(INDEXSIZE - 1);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t               state, state_nxt;
  logic [CLRW-1:0]      clr_cnt, clr_cnt_nxt;
  logic [LOGFIFO-1:0]   rd_ptr, wr_ptr, fwd_slot;
  logic [CNTW-1:0]      count;
  logic [LOGINDEX-1:0]  fifo_idx [FIFODEPTH];
  logic [DATAWIDTH-1:0] fifo_dat [FIFODEPTH];
  logic                 full, push, pop, flush;

  assign full = (count == FULL_CNT);
  assign push = upd_valid_in && upd_ready_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    ram_we_out    = 1'b0;
    ram_index_out = '0;
    ram_data_out  = '0;
    busy_out      = 1'b0;
    lkp_ready_out = 1'b1;
    upd_ready_out = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    case (state)
      RUN: begin
        upd_ready_out = !full && !clr_in;
        // A full FIFO steals the port from lookups so updates can never back up forever.
        if (full) begin
          pop           = 1'b1;
          ram_we_out    = 1'b1;
          ram_index_out = fifo_idx[rd_ptr];
          ram_data_out  = fifo_dat[rd_ptr];
          lkp_ready_out = 1'b0;
        end else if (lkp_valid_in) begin
          ram_index_out = lkp_index_in;
        end else if (count != '0) begin
          pop           = 1'b1;
          ram_we_out    = 1'b1;
          ram_index_out = fifo_idx[rd_ptr];
          ram_data_out  = fifo_dat[rd_ptr];
        end
        if (clr_in) begin
          flush       = 1'b1;
          clr_cnt_nxt = '0;
          state_nxt   = CLEAR;
        end
      end
      CLEAR: begin
        busy_out      = 1'b1;
        lkp_ready_out = 1'b0;
        ram_we_out    = 1'b1;
        ram_index_out = clr_cnt[LOGINDEX-1:0];
        ram_data_out  = INITVALUE;
        if (clr_in) begin
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + CLRW'(1);
          if (clr_cnt == LAST_IDX) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOGFIFO'(1);
      if (pop)  rd_ptr <= rd_ptr + LOGFIFO'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_idx[wr_ptr] <= upd_index_in;
      fifo_dat[wr_ptr] <= upd_data_in;
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest entry.
  always_comb begin
    lkp_data_out = ram_data_in;
    fwd_slot     = rd_ptr;
    for (int i = 0; i < FIFODEPTH; i++) begin
      fwd_slot = rd_ptr + LOGFIFO'(i);
      if ((CNTW'(i) < count) && (fifo_idx[fwd_slot] == lkp_index_in))
        lkp_data_out = fifo_dat[fwd_slot];
    end
  end

endmodule

// File: tb/tb_ram_sp_port_ctrl.sv
// Directed bench for ram_sp_port_ctrl: stimulus queues expected lookups/RAM writes,
// a negedge monitor pops and compares them whenever the DUT serves or writes.
module tb_ram_sp_port_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        lkp_valid_in;
  logic [7:0]  lkp_index_in;
  logic        lkp_ready_out;
  logic [63:0] lkp_data_out;
  logic        upd_valid_in;
  logic [7:0]  upd_index_in;
  logic [63:0] upd_data_in;
  logic        upd_ready_out;
  logic        clr_in;
  logic        busy_out;
  logic        ram_we_out;
  logic [7:0]  ram_index_out;
  logic [63:0] ram_data_out;
  logic [63:0] ram_data_in;

  logic [63:0] mem [256];
  logic [63:0] lkp_q [$];
  logic [71:0] wr_q  [$];
  int checks = 0;
  int errors = 0;
  int bcnt, lkp_bad;

  localparam logic [63:0] BASE = 64'hC0DE_0000_0000_0000;

  ram_sp_port_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .lkp_valid_in(lkp_valid_in), .lkp_index_in(lkp_index_in),
    .lkp_ready_out(lkp_ready_out), .lkp_data_out(lkp_data_out),
    .upd_valid_in(upd_valid_in), .upd_index_in(upd_index_in),
    .upd_data_in(upd_data_in), .upd_ready_out(upd_ready_out),
    .clr_in(clr_in), .busy_out(busy_out),
    .ram_we_out(ram_we_out), .ram_index_out(ram_index_out),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM with asynchronous read.
  assign ram_data_in = mem[ram_index_out];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = BASE | 64'(i);
    forever begin
      @(posedge clock);
      if (ram_we_out) mem[ram_index_out] <= ram_data_out;
    end
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (lkp_valid_in && lkp_ready_out) begin
        if (lkp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL lkp_unexpected: got %h expected none", lkp_data_out);
        end else begin
          chk("lkp_data", {8'd0, lkp_data_out}, {8'd0, lkp_q.pop_front()});
        end
      end
      if (ram_we_out) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got idx %h data %h expected none", ram_index_out, ram_data_out);
        end else begin
          chk("ram_write", {ram_index_out, ram_data_out}, wr_q.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    lkp_valid_in = 1'b0;
    upd_valid_in = 1'b0;
    clr_in       = 1'b0;
  endtask

  task automatic count_busy;
    bcnt = 0;
    lkp_bad = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (!busy_out) break;
      bcnt++;
      if (lkp_ready_out || upd_ready_out) lkp_bad++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    lkp_index_in = '0; upd_index_in = '0; upd_data_in = '0;
    repeat (2) tick();
    reset_n = 1'b1;

    // Reset state
    @(negedge clock);
    chk("rst_we", ram_we_out, 0);
    chk("rst_index", ram_index_out, 0);
    chk("rst_wdata", ram_data_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_lkp_ready", lkp_ready_out, 1);
    chk("rst_upd_ready", upd_ready_out, 1);
    chk("rst_lkp_data", lkp_data_out, BASE);
    tick();

    // Plain lookup from RAM
    lkp_valid_in = 1'b1; lkp_index_in = 8'd5;
    lkp_q.push_back(BASE | 64'h5);
    @(negedge clock);
    chk("lkp5_index", ram_index_out, 5);
    chk("lkp5_we", ram_we_out, 0);
    tick();

    // Single update, forwarded then written
    lkp_valid_in = 1'b0;
    upd_valid_in = 1'b1; upd_index_in = 8'd3; upd_data_in = 64'hAA;
    wr_q.push_back({8'd3, 64'hAA});
    @(negedge clock);
    chk("upd3_ready", upd_ready_out, 1);
    chk("upd3_no_early_write", ram_we_out, 0);
    tick();
    upd_valid_in = 1'b0;
    lkp_valid_in = 1'b1; lkp_index_in = 8'd3;
    lkp_q.push_back(64'hAA);
    @(negedge clock);
    chk("fwd3_we", ram_we_out, 0);
    tick();
    lkp_valid_in = 1'b0;
    @(negedge clock);
    chk("upd3_write_we", ram_we_out, 1);
    tick();
    lkp_valid_in = 1'b1; lkp_index_in = 8'd3;
    lkp_q.push_back(64'hAA);
    tick();

    // Two updates to the same index under busy lookups
    lkp_index_in = 8'd9; lkp_q.push_back(BASE | 64'h9);
    upd_valid_in = 1'b1; upd_index_in = 8'd7; upd_data_in = 64'h11;
    wr_q.push_back({8'd7, 64'h11});
    tick();
    lkp_index_in = 8'd7; lkp_q.push_back(64'h11);
    upd_data_in = 64'h22;
    wr_q.push_back({8'd7, 64'h22});
    tick();
    upd_valid_in = 1'b0;
    lkp_q.push_back(64'h22);
    tick();
    lkp_valid_in = 1'b0;
    @(negedge clock);
    chk("drain7_index", ram_index_out, 7);
    tick();
    tick();
    lkp_valid_in = 1'b1; lkp_index_in = 8'd7;
    lkp_q.push_back(64'h22);
    @(negedge clock);
    chk("drain7_done_we", ram_we_out, 0);
    tick();

    // Fill the FIFO under continuous lookups
    for (int k = 0; k < 4; k++) begin
      lkp_valid_in = 1'b1; lkp_index_in = 8'd1; lkp_q.push_back(BASE | 64'h1);
      upd_valid_in = 1'b1; upd_index_in = 8'(20 + k); upd_data_in = 64'(256 + k);
      wr_q.push_back({8'(20 + k), 64'(256 + k)});
      @(negedge clock);
      chk("fill_upd_ready", upd_ready_out, 1);
      tick();
    end
    upd_index_in = 8'd30; upd_data_in = 64'h300;
    @(negedge clock);
    chk("full_upd_ready", upd_ready_out, 0);
    chk("full_lkp_ready", lkp_ready_out, 0);
    chk("full_we", ram_we_out, 1);
    chk("full_index", ram_index_out, 20);
    tick();
    lkp_index_in = 8'd21; lkp_q.push_back(64'h101);
    wr_q.push_back({8'd30, 64'h300});
    @(negedge clock);
    chk("after_full_upd_ready", upd_ready_out, 1);
    chk("after_full_lkp_ready", lkp_ready_out, 1);
    tick();
    idle();
    repeat (4) tick();
    @(negedge clock);
    chk("fill_drained_we", ram_we_out, 0);
    tick();

    // Clear with two updates pending
    lkp_valid_in = 1'b1; lkp_index_in = 8'd2;
    upd_valid_in = 1'b1; upd_index_in = 8'd40; upd_data_in = 64'h400;
    lkp_q.push_back(BASE | 64'h2);
    tick();
    upd_index_in = 8'd41; upd_data_in = 64'h401;
    lkp_q.push_back(BASE | 64'h2);
    tick();
    upd_index_in = 8'd42; upd_data_in = 64'h402;
    clr_in = 1'b1;
    lkp_q.push_back(BASE | 64'h2);
    for (int i = 0; i < 256; i++) wr_q.push_back({8'(i), 64'd0});
    @(negedge clock);
    chk("clr_upd_ready", upd_ready_out, 0);
    chk("clr_cycle_we", ram_we_out, 0);
    tick();
    clr_in = 1'b0; upd_valid_in = 1'b0;
    lkp_q.push_back(64'd0);
    count_busy();
    chk("clr_busy_cycles", bcnt, 256);
    chk("clr_ready_low", lkp_bad, 0);
    tick();

    // Clear restarted at sweep index 100
    idle();
    clr_in = 1'b1;
    for (int i = 0; i <= 100; i++) wr_q.push_back({8'(i), 64'd0});
    for (int i = 0; i < 256; i++)  wr_q.push_back({8'(i), 64'd0});
    tick();
    clr_in = 1'b0;
    repeat (100) tick();
    clr_in = 1'b1;
    @(negedge clock);
    chk("restart_index", ram_index_out, 100);
    chk("restart_busy", busy_out, 1);
    tick();
    clr_in = 1'b0;
    count_busy();
    chk("restart_busy_cycles", bcnt, 256);
    chk("restart_ready_low", lkp_bad, 0);
    tick();

    // Reset in the middle of a sweep
    clr_in = 1'b1;
    for (int i = 0; i < 50; i++) wr_q.push_back({8'(i), 64'd0});
    tick();
    clr_in = 1'b0;
    repeat (50) tick();
    chk("sweep50_index", ram_index_out, 50);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy_out, 0);
    chk("midrst_we", ram_we_out, 0);
    chk("midrst_lkp_ready", lkp_ready_out, 1);
    tick();
    reset_n = 1'b1;
    lkp_valid_in = 1'b1; lkp_index_in = 8'd5;
    lkp_q.push_back(64'd0);
    @(negedge clock);
    chk("postrst_upd_ready", upd_ready_out, 1);
    chk("postrst_index", ram_index_out, 5);
    tick();
    idle();
    tick();

    chk("wr_q_empty", wr_q.size(), 0);
    chk("lkp_q_empty", lkp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
